adt7420_poller: RTL and testbench

Upstream command sequencer for i2c_master. Once enabled, it configures the ADT7420 at 7'h4B for 16-bit resolution. It then periodically issues 2-byte reads of the temperature register, assembles the result and publishes it with a valid strobe. It owns retry and error policy, so i2c_master stays a pure transaction engine.

---
 rtl/adt7420_poller.sv | 206 ++++++++++++++++++++
 tb/tb_adt7420_poller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_poller.sv
// ADT7420 temperature poller: configures the sensor for 16-bit mode, then
// issues periodic 2-byte reads through i2c_master with retry/backoff handling.
//
// state     | meaning
// IDLE      | disabled, waiting for i_enable
// CFG_REQ   | waiting for master idle, then issue config write
// CFG_START | config issued, waiting for i_busy (with timeout)
// CFG_RUN   | config write in flight
// CFG_CHECK | evaluate config result
// RD_REQ    | waiting for master idle, then issue temperature read
// RD_START  | read issued, waiting for i_busy (with timeout)
// RD_RUN    | read in flight, collecting bytes
// RD_CHECK  | evaluate read result, publish reading
// BACKOFF   | pause before retrying the failed transaction
// WAIT      | waiting for the next poll period
module adt7420_poller #(
  parameter logic [6:0] I2C_ADDR         = 7'h4B,
  parameter logic [7:0] CFG_VALUE        = 8'h80,
  parameter int         POLL_PERIOD_CYC  = 25_000_000,
  parameter int         BUSY_TIMEOUT_CYC = 16,
  parameter int         MAX_RETRY        = 3,
  parameter int         BACKOFF_CYC      = 1000
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        i_enable,
  output logic [7:0]  o_addr_w_rw,
  output logic [15:0] o_sub_addr,
  output logic        o_sub_len,
  output logic [23:0] o_byte_len,
  output logic [7:0]  o_data_write,
  output logic        o_req_trans,
  input  logic [7:0]  i_data_out,
  input  logic        i_valid_out,
  input  logic        i_req_data_chunk,
  input  logic        i_busy,
  input  logic        i_nack,
  output logic [15:0] o_temp_raw,
  output logic [8:0]  o_temp_int,
  output logic        o_temp_valid,
  output logic        o_cfg_done,
  output logic        o_error
);

  localparam int TMR_MAX = (BACKOFF_CYC > BUSY_TIMEOUT_CYC) ? BACKOFF_CYC : BUSY_TIMEOUT_CYC;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int PW = $clog2(POLL_PERIOD_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, CFG_REQ, CFG_START, CFG_RUN, CFG_CHECK,
    RD_REQ, RD_START, RD_RUN, RD_CHECK, BACKOFF, WAIT
  } state_t;

  state_t         state;
  logic [TW-1:0]  tmr;
  logic [PW-1:0]  poll_cnt;
  logic [RW-1:0]  retry;
  logic [RW-1:0]  retry_nxt;
  logic           is_rd;
  logic           fail;
  logic [1:0]     rx_cnt;
  logic [7:0]     rx_msb;
  logic [7:0]     rx_lsb;
  logic [7:0]     chunk_cnt_unused;
  logic           txn_ok;

  always_comb begin
    retry_nxt = retry + 1'b1;
    txn_ok    = !fail && (!is_rd || rx_cnt == 2'd2);
  end

  assign o_sub_len = 1'b0;

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      tmr              <= '0;
      poll_cnt         <= '0;
      retry            <= '0;
      is_rd            <= 1'b0;
      fail             <= 1'b0;
      rx_cnt           <= '0;
      rx_msb           <= '0;
      rx_lsb           <= '0;
      chunk_cnt_unused <= '0;
      o_addr_w_rw      <= {I2C_ADDR, 1'b0};
      o_sub_addr       <= '0;
      o_byte_len       <= '0;
      o_data_write     <= '0;
      o_req_trans      <= 1'b0;
      o_temp_raw       <= '0;
      o_temp_int       <= '0;
      o_temp_valid     <= 1'b0;
      o_cfg_done       <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_req_trans  <= 1'b0;
      o_temp_valid <= 1'b0;
      // poll counter parks at zero, which also remembers an expired period
      if (poll_cnt != '0) poll_cnt <= poll_cnt - 1'b1;
      if (i_req_data_chunk) chunk_cnt_unused <= chunk_cnt_unused + 1'b1;

      case (state)
        IDLE: begin
          o_cfg_done <= 1'b0;
          retry      <= '0;
          if (i_enable) state <= CFG_REQ;
        end

        CFG_REQ, RD_REQ: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (!i_busy) begin
            o_req_trans      <= 1'b1;
            fail             <= 1'b0;
            rx_cnt           <= '0;
            chunk_cnt_unused <= '0;
            tmr              <= TW'(BUSY_TIMEOUT_CYC - 1);
            if (state == RD_REQ) begin
              o_addr_w_rw  <= {I2C_ADDR, 1'b1};
              o_sub_addr   <= 16'h0000;
              o_byte_len   <= 24'd2;
              o_data_write <= 8'h00;
              is_rd        <= 1'b1;
              state        <= RD_START;
              // only a first attempt restarts the poll period
              if (retry == '0) poll_cnt <= PW'(POLL_PERIOD_CYC - 2);
            end else begin
              o_addr_w_rw  <= {I2C_ADDR, 1'b0};
              o_sub_addr   <= 16'h0003;
              o_byte_len   <= 24'd1;
              o_data_write <= CFG_VALUE;
              is_rd        <= 1'b0;
              state        <= CFG_START;
            end
          end
        end

        CFG_START, RD_START: begin
          if (i_nack) fail <= 1'b1;
          if (i_busy) begin
            state <= is_rd ? RD_RUN : CFG_RUN;
          end else if (tmr == '0) begin
            fail  <= 1'b1;
            state <= is_rd ? RD_CHECK : CFG_CHECK;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        CFG_RUN, RD_RUN: begin
          if (i_nack) fail <= 1'b1;
          if (i_valid_out && is_rd && rx_cnt != 2'd2) begin
            if (rx_cnt == 2'd0) rx_msb <= i_data_out;
            else                rx_lsb <= i_data_out;
            rx_cnt <= rx_cnt + 1'b1;
          end
          if (!i_busy) state <= is_rd ? RD_CHECK : CFG_CHECK;
        end

        CFG_CHECK, RD_CHECK: begin
          if (txn_ok) begin
            o_error <= 1'b0;
            retry   <= '0;
            if (is_rd) begin
              o_temp_raw   <= {rx_msb, rx_lsb};
              o_temp_int   <= {rx_msb, rx_lsb[7]};
              o_temp_valid <= 1'b1;
              state        <= WAIT;
            end else begin
              o_cfg_done <= 1'b1;
              state      <= RD_REQ;
            end
          end else if (retry_nxt < RW'(MAX_RETRY)) begin
            retry <= retry_nxt;
            tmr   <= TW'(BACKOFF_CYC - 1);
            state <= BACKOFF;
          end else begin
            o_error <= 1'b1;
            retry   <= '0;
            state   <= is_rd ? WAIT : RD_REQ;
          end
          if (!i_enable) begin
            o_cfg_done <= 1'b0;
            state      <= IDLE;
          end
        end

        BACKOFF: begin
          if (!i_enable)        state <= IDLE;
          else if (tmr == '0)   state <= is_rd ? RD_REQ : CFG_REQ;
          else                  tmr   <= tmr - 1'b1;
        end

        WAIT: begin
          if (!i_enable)             state <= IDLE;
          else if (poll_cnt == '0)   state <= RD_REQ;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adt7420_poller.sv
// Directed bench for adt7420_poller with a behavioural i2c_master responder.
module tb_adt7420_poller;

  localparam int POLL = 2000;
  localparam int TOUT = 16;
  localparam int BOFF = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_enable;
  logic [7:0]  o_addr_w_rw;
  logic [15:0] o_sub_addr;
  logic        o_sub_len;
  logic [23:0] o_byte_len;
  logic [7:0]  o_data_write;
  logic        o_req_trans;
  logic [7:0]  i_data_out;
  logic        i_valid_out;
  logic        i_req_data_chunk;
  logic        i_busy;
  logic        i_nack;
  logic [15:0] o_temp_raw;
  logic [8:0]  o_temp_int;
  logic        o_temp_valid;
  logic        o_cfg_done;
  logic        o_error;

  adt7420_poller #(
    .POLL_PERIOD_CYC(POLL), .BUSY_TIMEOUT_CYC(TOUT), .MAX_RETRY(3), .BACKOFF_CYC(BOFF)
  ) dut (
    .i_clk(clk), .reset_n(reset_n), .i_enable(i_enable),
    .o_addr_w_rw(o_addr_w_rw), .o_sub_addr(o_sub_addr), .o_sub_len(o_sub_len),
    .o_byte_len(o_byte_len), .o_data_write(o_data_write), .o_req_trans(o_req_trans),
    .i_data_out(i_data_out), .i_valid_out(i_valid_out), .i_req_data_chunk(i_req_data_chunk),
    .i_busy(i_busy), .i_nack(i_nack), .o_temp_raw(o_temp_raw), .o_temp_int(o_temp_int),
    .o_temp_valid(o_temp_valid), .o_cfg_done(o_cfg_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int req_cnt = 0;
  int valid_cnt = 0;
  int req_cyc [64];
  int fall_cyc = 0;
  logic [7:0]  cap_addr;
  logic [15:0] cap_sub;
  logic [23:0] cap_len;
  logic [7:0]  cap_data;
  logic        cap_sub_len;
  int   nack_left = 0;
  bit   stuck = 0;
  logic [7:0] rd_msb = 8'h00;
  logic [7:0] rd_lsb = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (o_temp_valid) valid_cnt = valid_cnt + 1;
  end

  // responder: reacts to each o_req_trans like a simplified i2c_master
  initial begin
    bit do_nack;
    i_busy = 0; i_nack = 0; i_valid_out = 0; i_data_out = 0; i_req_data_chunk = 0;
    forever begin
      @(negedge clk);
      if (o_req_trans) begin
        req_cnt = req_cnt + 1;
        if (req_cnt < 64) req_cyc[req_cnt] = cyc;
        cap_addr = o_addr_w_rw; cap_sub = o_sub_addr; cap_len = o_byte_len;
        cap_data = o_data_write; cap_sub_len = o_sub_len;
        if (!stuck) begin
          do_nack = (nack_left > 0);
          if (do_nack) nack_left = nack_left - 1;
          @(negedge clk); i_busy = 1;
          @(negedge clk);
          if (do_nack) begin
            i_nack = 1; @(negedge clk); i_nack = 0;
          end else if (cap_addr[0]) begin
            i_valid_out = 1; i_data_out = rd_msb; @(negedge clk);
            i_data_out = rd_lsb; @(negedge clk);
            i_valid_out = 0;
          end else begin
            i_req_data_chunk = 1; @(negedge clk); i_req_data_chunk = 0;
          end
          @(negedge clk); i_busy = 0; fall_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_req(input int target, input int max_cyc, output bit ok);
    int n = 0;
    while (req_cnt < target && n < max_cyc) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    ok = (req_cnt >= target);
  endtask

  task automatic wait_valid(input int target, input int max_cyc, output bit ok);
    int n = 0;
    while (valid_cnt < target && n < max_cyc) begin
      @(negedge clk); n++;
    end
    ok = (valid_cnt >= target);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 0; i_enable = 0;
    idle(3);
    vec++;
    if ({o_addr_w_rw, o_sub_addr, o_sub_len, o_byte_len, o_data_write, o_req_trans} !== {8'h96, 16'h0, 1'b0, 24'h0, 8'h0, 1'b0}) begin
      errs++; $display("FAIL reset_cmd got addr=%h sub=%h len=%h data=%h req=%b", o_addr_w_rw, o_sub_addr, o_byte_len, o_data_write, o_req_trans);
    end
    vec++;
    if ({o_temp_raw, o_temp_int, o_temp_valid, o_cfg_done, o_error} !== 29'h0) begin
      errs++; $display("FAIL reset_status got raw=%h int=%h v=%b cfg=%b err=%b want all 0", o_temp_raw, o_temp_int, o_temp_valid, o_cfg_done, o_error);
    end
    reset_n = 1;
    idle(5);
    vec++;
    if (req_cnt !== 0) begin
      errs++; $display("FAIL idle_no_req got %0d requests want 0", req_cnt);
    end
  endtask

  task automatic test_config_and_first_read;
    bit ok;
    rd_msb = 8'h0C; rd_lsb = 8'h80;
    i_enable = 1;
    wait_req(1, 50, ok);
    vec++;
    if (!ok || {cap_addr, cap_sub, cap_sub_len, cap_len, cap_data} !== {8'h96, 16'h0003, 1'b0, 24'd1, 8'h80}) begin
      errs++; $display("FAIL cfg_write got ok=%b addr=%h sub=%h sl=%b len=%0d data=%h want 96/0003/0/1/80", ok, cap_addr, cap_sub, cap_sub_len, cap_len, cap_data);
    end
    wait_req(2, 50, ok);
    vec++;
    if (!ok || o_cfg_done !== 1'b1) begin
      errs++; $display("FAIL cfg_done got ok=%b cfg_done=%b want 1", ok, o_cfg_done);
    end
    vec++;
    if ({cap_addr, cap_sub, cap_len} !== {8'h97, 16'h0000, 24'd2}) begin
      errs++; $display("FAIL rd_cmd got addr=%h sub=%h len=%0d want 97/0000/2", cap_addr, cap_sub, cap_len);
    end
    wait_valid(1, 50, ok);
    idle(3);
    vec++;
    if (!ok || o_temp_raw !== 16'h0C80 || o_temp_int !== 9'd25 || valid_cnt !== 1) begin
      errs++; $display("FAIL first_read got raw=%h int=%0d pulses=%0d want 0c80/25/1", o_temp_raw, o_temp_int, valid_cnt);
    end
  endtask

  task automatic test_poll_period;
    bit ok;
    rd_msb = 8'hFF; rd_lsb = 8'h80;
    wait_req(3, POLL + 100, ok);
    vec++;
    if (!ok || req_cyc[3] - req_cyc[2] != POLL) begin
      errs++; $display("FAIL poll_gap1 got %0d cycles want %0d", req_cyc[3] - req_cyc[2], POLL);
    end
    wait_valid(2, 50, ok);
    vec++;
    if (!ok || o_temp_raw !== 16'hFF80 || o_temp_int !== 9'h1FF) begin
      errs++; $display("FAIL neg_read got raw=%h int=%h want ff80/1ff", o_temp_raw, o_temp_int);
    end
    rd_msb = 8'h00; rd_lsb = 8'h00;
    wait_req(4, POLL + 100, ok);
    vec++;
    if (!ok || req_cyc[4] - req_cyc[3] != POLL) begin
      errs++; $display("FAIL poll_gap2 got %0d cycles want %0d", req_cyc[4] - req_cyc[3], POLL);
    end
    wait_valid(3, 50, ok);
    vec++;
    if (!ok || o_temp_raw !== 16'h0000 || o_temp_int !== 9'h000) begin
      errs++; $display("FAIL zero_read got raw=%h int=%h want 0000/000", o_temp_raw, o_temp_int);
    end
  endtask

  task automatic test_retry_recovers;
    bit ok;
    int gap;
    rd_msb = 8'h19; rd_lsb = 8'h00;
    nack_left = 2;
    wait_req(5, POLL + 100, ok);
    for (int k = 6; k <= 7; k++) begin
      wait_req(k, BOFF + 100, ok);
      gap = req_cyc[k] - fall_cyc;
      vec++;
      if (!ok || gap < BOFF || gap > BOFF + 5) begin
        errs++; $display("FAIL backoff_gap%0d got %0d cycles want %0d..%0d", k, gap, BOFF, BOFF + 5);
      end
    end
    wait_valid(4, 50, ok);
    vec++;
    if (!ok || o_error !== 1'b0 || o_temp_raw !== 16'h1900 || o_temp_int !== 9'd50) begin
      errs++; $display("FAIL retry_read got err=%b raw=%h int=%0d want 0/1900/50", o_error, o_temp_raw, o_temp_int);
    end
  endtask

  task automatic test_all_nack;
    bit ok;
    nack_left = 3;
    wait_req(8, POLL + 100, ok);
    vec++;
    if (!ok || req_cyc[8] - req_cyc[5] != POLL) begin
      errs++; $display("FAIL poll_after_retry got %0d cycles want %0d", req_cyc[8] - req_cyc[5], POLL);
    end
    wait_req(10, 2 * BOFF + 100, ok);
    idle(100);
    vec++;
    if (!ok || req_cnt !== 10 || o_error !== 1'b1) begin
      errs++; $display("FAIL nack_exhaust got reqs=%0d err=%b want 10/1", req_cnt, o_error);
    end
    vec++;
    if (valid_cnt !== 4 || o_temp_raw !== 16'h1900) begin
      errs++; $display("FAIL nack_hold got pulses=%0d raw=%h want 4/1900", valid_cnt, o_temp_raw);
    end
    rd_msb = 8'h0D; rd_lsb = 8'h00;
    wait_req(11, POLL + 100, ok);
    wait_valid(5, 50, ok);
    vec++;
    if (!ok || o_error !== 1'b0 || o_temp_raw !== 16'h0D00) begin
      errs++; $display("FAIL err_clear got err=%b raw=%h want 0/0d00", o_error, o_temp_raw);
    end
  endtask

  task automatic test_busy_timeout;
    bit ok;
    int gap;
    stuck = 1;
    wait_req(12, POLL + 100, ok);
    wait_req(13, TOUT + BOFF + 100, ok);
    gap = req_cyc[13] - req_cyc[12];
    vec++;
    if (!ok || gap < TOUT + BOFF || gap > TOUT + BOFF + 5) begin
      errs++; $display("FAIL timeout_gap got %0d cycles want %0d..%0d", gap, TOUT + BOFF, TOUT + BOFF + 5);
    end
    wait_req(14, TOUT + BOFF + 100, ok);
    idle(TOUT + 40);
    vec++;
    if (!ok || req_cnt !== 14 || o_error !== 1'b1 || valid_cnt !== 5) begin
      errs++; $display("FAIL timeout_exhaust got reqs=%0d err=%b pulses=%0d want 14/1/5", req_cnt, o_error, valid_cnt);
    end
    stuck = 0;
  endtask

  task automatic test_enable_drop_and_reset;
    bit ok;
    int n;
    rd_msb = 8'h0A; rd_lsb = 8'h00;
    wait_req(15, POLL + 100, ok);
    n = 0;
    while (!i_busy && n < 20) begin @(negedge clk); n++; end
    i_enable = 0;
    wait_valid(6, 50, ok);
    idle(5);
    vec++;
    if (!ok || o_temp_raw !== 16'h0A00 || o_cfg_done !== 1'b0 || o_error !== 1'b0) begin
      errs++; $display("FAIL drop_enable got raw=%h cfg=%b err=%b want 0a00/0/0", o_temp_raw, o_cfg_done, o_error);
    end
    idle(POLL + 50);
    vec++;
    if (req_cnt !== 15) begin
      errs++; $display("FAIL disabled_quiet got reqs=%0d want 15", req_cnt);
    end
    i_enable = 1;
    wait_req(16, 50, ok);
    vec++;
    if (!ok || {cap_addr, cap_sub, cap_data} !== {8'h96, 16'h0003, 8'h80}) begin
      errs++; $display("FAIL reenable_cfg got addr=%h sub=%h data=%h want 96/0003/80", cap_addr, cap_sub, cap_data);
    end
    wait_req(17, 50, ok);
    n = 0;
    while (!i_busy && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    reset_n = 0;
    #1;
    vec++;
    if (!ok || {o_addr_w_rw, o_req_trans, o_temp_raw, o_temp_int, o_temp_valid, o_cfg_done, o_error, o_byte_len} !== {8'h96, 1'b0, 16'h0, 9'h0, 3'b000, 24'h0}) begin
      errs++; $display("FAIL async_reset got addr=%h raw=%h int=%h cfg=%b err=%b len=%h want 96/0/0/0/0/0", o_addr_w_rw, o_temp_raw, o_temp_int, o_cfg_done, o_error, o_byte_len);
    end
    i_enable = 0;
    idle(20);
    reset_n = 1;
    idle(50);
    vec++;
    if (req_cnt !== 17 || valid_cnt !== 6) begin
      errs++; $display("FAIL post_reset_idle got reqs=%0d pulses=%0d want 17/6", req_cnt, valid_cnt);
    end
  endtask

  initial begin
    reset_n = 0;
    i_enable = 0;
    test_reset;
    test_config_and_first_read;
    test_poll_period;
    test_retry_recovers;
    test_all_nack;
    test_busy_timeout;
    test_enable_drop_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
